// File: rtl/wmem_pkg.sv
// Shared packet format, opcodes and FSM states for the weight memory/distributor.
package wmem_pkg;

    localparam int ADDR_W   = 4;
    localparam int OP_W     = 4;
    localparam int DATA_W   = 25;
    localparam int PKT_W    = ADDR_W + OP_W + DATA_W;
    localparam int DATA_LSB = 0;
    localparam int OP_LSB   = DATA_LSB + DATA_W;
    localparam int DEST_LSB = OP_LSB + OP_W;

    localparam logic [OP_W-1:0] OP_WEIGHT        = 4'd0;
    localparam logic [OP_W-1:0] OP_TIMESTEP_DONE = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED,
        ST_SEND,
        ST_WAIT_TS
    } state_e;

    function automatic logic [PKT_W-1:0] build_pkt(input logic [ADDR_W-1:0] dest,
                                                   input logic [OP_W-1:0]   op,
                                                   input logic [DATA_W-1:0] data);
        logic [PKT_W-1:0] pkt;
        pkt = '0;
        pkt[DEST_LSB +: ADDR_W] = dest;
        pkt[OP_LSB   +: OP_W]   = op;
        pkt[DATA_LSB +: DATA_W] = data;
        return pkt;
    endfunction

endpackage

// File: rtl/wmem_dist_if.sv
// Loader/router-side handshake bundle of wmem_dist; master = loader/router side, slave = wmem_dist.
interface wmem_dist_if #(
    parameter int WEIGHT_W = 8,
    parameter int WADDR_W  = 12
);
    import wmem_pkg::*;

    logic                load_start_valid;
    logic                load_start_ready;
    logic                wr_valid;
    logic                wr_ready;
    logic [WADDR_W-1:0]  wr_addr;
    logic [WEIGHT_W-1:0] wr_data;
    logic                load_done_valid;
    logic                load_done_ready;
    logic                rin_valid;
    logic                rin_ready;
    logic [PKT_W-1:0]    rin_data;
    logic                rout_valid;
    logic                rout_ready;
    logic [PKT_W-1:0]    rout_data;
    logic                busy;
    logic                err;

    modport master (
        output load_start_valid, wr_valid, wr_addr, wr_data, load_done_valid,
               rin_valid, rin_data, rout_ready,
        input  load_start_ready, wr_ready, load_done_ready, rin_ready,
               rout_valid, rout_data, busy, err
    );

    modport slave (
        input  load_start_valid, wr_valid, wr_addr, wr_data, load_done_valid,
               rin_valid, rin_data, rout_ready,
        output load_start_ready, wr_ready, load_done_ready, rin_ready,
               rout_valid, rout_data, busy, err
    );

endinterface

// File: rtl/wmem_pack.sv
// Row-chunk packer: places columns chunk*WPP.. of one filter row into a packet payload, column chunk*WPP at the LSBs.
// Purely combinational; no handshake.
module wmem_pack
    import wmem_pkg::*;
#(
    parameter int WEIGHT_W    = 8,
    parameter int FILTER_SIZE = 5,
    parameter int WPP         = 3,
    parameter int KW          = 1
) (
    input  logic [FILTER_SIZE*WEIGHT_W-1:0] row_i,
    input  logic [KW-1:0]                   chunk_i,
    output logic [DATA_W-1:0]               data_o
);

    int col;

    always_comb begin
        data_o = '0;
        col    = 0;
        for (int j = 0; j < WPP; j++) begin
            col = int'(chunk_i) * WPP + j;
            if (col < FILTER_SIZE) begin
                data_o[j*WEIGHT_W +: WEIGHT_W] = row_i[col*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

endmodule

// File: rtl/wmem_dist.sv
// Filter-weight memory that streams every filter row as weight packets to consecutive PEs, replaying once per timestep.
// Registered rout: first packet one cycle after load_done/timestep-done accept, then one per cycle; held stable while rout_ready is low.
module wmem_dist
    import wmem_pkg::*;
#(
    parameter int WEIGHT_W    = 8,
    parameter int FILTER_SIZE = 5,
    parameter int NUM_FILTERS = 2,
    parameter int PE_BASE     = 5,
    parameter int NUM_TS      = 2,
    parameter int WADDR_W     = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    wmem_dist_if.slave dist_if
);

    localparam int NW     = NUM_FILTERS * FILTER_SIZE * FILTER_SIZE;
    localparam int WPP    = DATA_W / WEIGHT_W;
    localparam int WPP_G  = (WPP < 1) ? 1 : WPP;
    localparam int NCHUNK = (FILTER_SIZE + WPP_G - 1) / WPP_G;
    localparam int AW     = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW     = $clog2(NW + 1);
    localparam int FW     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int RW     = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int TW     = $clog2(NUM_TS + 1);

    if (PE_BASE + NUM_FILTERS * FILTER_SIZE - 1 >= (1 << ADDR_W)) begin : g_chk_dest
        $error("wmem_dist: destination PE IDs overflow the packet address field");
    end
    if (NW >= (1 << WADDR_W)) begin : g_chk_waddr
        $error("wmem_dist: weight count does not fit the write-address width");
    end
    if (WPP < 1) begin : g_chk_wpp
        $error("wmem_dist: a weight does not fit in the packet payload");
    end

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [TW-1:0]       ts_q, ts_d;
    logic [FW-1:0]       f_q, f_d, nf, pf;
    logic [RW-1:0]       r_q, r_d, nr, pr;
    logic [KW-1:0]       k_q, k_d, nk, pk;
    logic                rout_vld_q, rout_vld_d;
    logic [PKT_W-1:0]    rout_dat_q, rout_dat_d;
    logic [WEIGHT_W-1:0] mem_q [NW];
    logic                mem_we;
    logic                last_chunk;
    logic                load_pkt;
    logic [TW-1:0]       ts_inc;
    logic [AW-1:0]       ridx;
    logic [FILTER_SIZE*WEIGHT_W-1:0] row_dat;
    logic [DATA_W-1:0]   pack_dat;
    logic [ADDR_W-1:0]   dest;

    // Index of the chunk after the one currently presented on rout.
    always_comb begin
        nf = f_q;
        nr = r_q;
        nk = k_q + KW'(1);
        last_chunk = (f_q == FW'(NUM_FILTERS - 1)) && (r_q == RW'(FILTER_SIZE - 1)) &&
                     (k_q == KW'(NCHUNK - 1));
        if (k_q == KW'(NCHUNK - 1)) begin
            nk = '0;
            nr = r_q + RW'(1);
            if (r_q == RW'(FILTER_SIZE - 1)) begin
                nr = '0;
                nf = f_q + FW'(1);
            end
        end
    end

    // Outside SEND the only packet ever loaded is the first of a pass.
    assign pf   = (state_q == ST_SEND) ? nf : '0;
    assign pr   = (state_q == ST_SEND) ? nr : '0;
    assign pk   = (state_q == ST_SEND) ? nk : '0;
    assign dest = ADDR_W'(PE_BASE + int'(pf) * FILTER_SIZE + int'(pr));

    always_comb begin
        row_dat = '0;
        ridx    = '0;
        for (int c = 0; c < FILTER_SIZE; c++) begin
            ridx = AW'((int'(pf) * FILTER_SIZE + int'(pr)) * FILTER_SIZE + c);
            row_dat[c*WEIGHT_W +: WEIGHT_W] = mem_q[ridx];
        end
    end

    wmem_pack #(
        .WEIGHT_W   (WEIGHT_W),
        .FILTER_SIZE(FILTER_SIZE),
        .WPP        (WPP_G),
        .KW         (KW)
    ) u_pack (
        .row_i  (row_dat),
        .chunk_i(pk),
        .data_o (pack_dat)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ts_d       = ts_q;
        f_d        = f_q;
        r_d        = r_q;
        k_d        = k_q;
        rout_vld_d = rout_vld_q;
        rout_dat_d = rout_dat_q;
        mem_we     = 1'b0;
        load_pkt   = 1'b0;
        ts_inc     = ts_q + TW'(1);
        dist_if.load_start_ready = 1'b0;
        dist_if.wr_ready         = 1'b0;
        dist_if.load_done_ready  = 1'b0;
        dist_if.rin_ready        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dist_if.load_start_ready = 1'b1;
                if (dist_if.load_start_valid) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    ts_d    = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dist_if.wr_ready = 1'b1;
                if (dist_if.wr_valid) begin
                    if (int'(dist_if.wr_addr) < NW) begin
                        mem_we = 1'b1;
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q == CW'(NW - 1)) state_d = ST_ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                dist_if.load_done_ready = 1'b1;
                if (dist_if.load_done_valid) begin
                    load_pkt = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (dist_if.rout_ready) begin
                    if (last_chunk) begin
                        rout_vld_d = 1'b0;
                        ts_d       = ts_inc;
                        state_d    = (ts_inc == TW'(NUM_TS)) ? ST_IDLE : ST_WAIT_TS;
                    end else begin
                        load_pkt = 1'b1;
                    end
                end
            end
            ST_WAIT_TS: begin
                dist_if.rin_ready = 1'b1;
                if (dist_if.rin_valid) begin
                    if (dist_if.rin_data[OP_LSB +: OP_W] == OP_TIMESTEP_DONE) begin
                        load_pkt = 1'b1;
                        state_d  = ST_SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_pkt) begin
            f_d        = pf;
            r_d        = pr;
            k_d        = pk;
            rout_vld_d = 1'b1;
            rout_dat_d = build_pkt(dest, OP_WEIGHT, pack_dat);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ts_q       <= '0;
            f_q        <= '0;
            r_q        <= '0;
            k_q        <= '0;
            rout_vld_q <= 1'b0;
            rout_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ts_q       <= ts_d;
            f_q        <= f_d;
            r_q        <= r_d;
            k_q        <= k_d;
            rout_vld_q <= rout_vld_d;
            rout_dat_q <= rout_dat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[dist_if.wr_addr[AW-1:0]] <= dist_if.wr_data;
        end
    end

    assign dist_if.rout_valid = rout_vld_q;
    assign dist_if.rout_data  = rout_dat_q;
    assign dist_if.busy       = (state_q != ST_IDLE);
    assign dist_if.err        = err_q;

endmodule

// File: tb/tb_wmem_dist.sv
// Directed bench for wmem_dist: load, two passes, stall, bad address/opcode, early load_done, reset mid-send.
module tb_wmem_dist;
    import wmem_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [PKT_W-1:0] got [20];

    wmem_dist_if #(.WEIGHT_W(8), .WADDR_W(12)) bus ();

    wmem_dist #(
        .WEIGHT_W(8), .FILTER_SIZE(5), .NUM_FILTERS(2),
        .PE_BASE(5), .NUM_TS(2), .WADDR_W(12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dist_if(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packet p of a pass when weight i holds i+off: 10 packets per filter, 2 per row.
    function automatic logic [PKT_W-1:0] exp_pkt(input int p, input int off);
        int f, r, k;
        logic [24:0] d;
        logic [3:0]  dst;
        f = p / 10;
        r = (p % 10) / 2;
        k = p % 2;
        d = '0;
        for (int j = 0; j < 3; j++)
            if (k * 3 + j < 5) d[j*8 +: 8] = 8'(f * 25 + r * 5 + k * 3 + j + off);
        dst = 4'(5 + f * 5 + r);
        return {dst, 4'd0, d};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.load_start_ready, bus.wr_ready, bus.load_done_ready, bus.rin_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_readies got=%b want=1000",
                     {bus.load_start_ready, bus.wr_ready, bus.load_done_ready, bus.rin_ready});
        end
        checks++;
        if (bus.rout_valid !== 1'b0 || bus.rout_data !== '0) begin
            failures++;
            $display("FAIL reset_rout got vld=%b dat=%h want vld=0 dat=0", bus.rout_valid, bus.rout_data);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b err=%b want 0 0", bus.busy, bus.err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.load_start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rout_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got lsr=%b busy=%b vld=%b want 1 0 0",
                     bus.load_start_ready, bus.busy, bus.rout_valid);
        end
    endtask

    task automatic do_load(input int off, input bit bad, input bit early);
        checks++;
        if (bus.load_start_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_start_ready got=%b want=1", bus.load_start_ready);
        end
        bus.load_start_valid = 1'b1;
        @(posedge clk); #1;
        bus.load_start_valid = 1'b0;
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL load_entry got wr_rdy=%b err=%b busy=%b want 1 0 1", bus.wr_ready, bus.err, bus.busy);
        end
        for (int i = 0; i < 50; i++) begin
            if (bad && i == 20) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = 12'd60;
                bus.wr_data  = 8'hEE;
                @(posedge clk); #1;
                checks++;
                if (bus.err !== 1'b1) begin
                    failures++;
                    $display("FAIL bad_addr_err got=%b want=1", bus.err);
                end
            end
            if (early && i == 30) bus.load_done_valid = 1'b1;
            if (early && i >= 30) begin
                checks++;
                if (bus.load_done_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL early_done_accepted write=%0d got rdy=%b want 0", i, bus.load_done_ready);
                end
            end
            checks++;
            if (bus.wr_ready !== 1'b1) begin
                failures++;
                $display("FAIL wr_ready write=%0d got=%b want=1", i, bus.wr_ready);
            end
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 12'(i);
            bus.wr_data  = 8'(i + off);
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.wr_ready !== 1'b0 || bus.load_done_ready !== 1'b1 || bus.rout_valid !== 1'b0) begin
            failures++;
            $display("FAIL armed got wr_rdy=%b ld_rdy=%b vld=%b want 0 1 0",
                     bus.wr_ready, bus.load_done_ready, bus.rout_valid);
        end
    endtask

    // Expects packet 0 on rout now, then one packet per cycle; stalls 5 cycles on packet stall_at.
    task automatic collect(input int off, input int stall_at, input int npk);
        logic [PKT_W-1:0] held;
        for (int p = 0; p < npk; p++) begin
            if (p == stall_at) begin
                bus.rout_ready = 1'b0;
                held = bus.rout_data;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (bus.rout_valid !== 1'b1 || bus.rout_data !== held) begin
                        failures++;
                        $display("FAIL stall_hold cyc=%0d got vld=%b dat=%h want 1 %h",
                                 s, bus.rout_valid, bus.rout_data, held);
                    end
                end
                bus.rout_ready = 1'b1;
            end
            checks++;
            if ({bus.rout_valid, bus.rout_data} !== {1'b1, exp_pkt(p, off)}) begin
                failures++;
                $display("FAIL pkt%0d got vld=%b dat=%h want 1 %h", p, bus.rout_valid, bus.rout_data, exp_pkt(p, off));
            end
            got[p] = bus.rout_data;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_first_pass();
        do_load(0, 1'b0, 1'b0);
        bus.rout_ready      = 1'b1;
        bus.load_done_valid = 1'b1;
        @(posedge clk); #1;
        bus.load_done_valid = 1'b0;
        collect(0, -1, 20);
        checks++;
        if (got[0] !== {4'd5, 4'd0, 25'h020100}) begin
            failures++;
            $display("FAIL spec_pkt0 got=%h want=%h", got[0], {4'd5, 4'd0, 25'h020100});
        end
        checks++;
        if (got[1] !== {4'd5, 4'd0, 25'h000403}) begin
            failures++;
            $display("FAIL spec_pkt1 got=%h want=%h", got[1], {4'd5, 4'd0, 25'h000403});
        end
        checks++;
        if (got[19] !== {4'd14, 4'd0, 25'h003130}) begin
            failures++;
            $display("FAIL spec_pkt19 got=%h want=%h", got[19], {4'd14, 4'd0, 25'h003130});
        end
        checks++;
        if ({bus.rout_valid, bus.busy, bus.rin_ready, bus.load_start_ready, bus.err} !== 5'b01100) begin
            failures++;
            $display("FAIL wait_ts got vld/busy/rin/lsr/err=%b want 01100",
                     {bus.rout_valid, bus.busy, bus.rin_ready, bus.load_start_ready, bus.err});
        end
    endtask

    task automatic test_replay();
        bus.rin_valid = 1'b1;
        bus.rin_data  = {4'd0, 4'd3, 25'd7};
        @(posedge clk); #1;
        bus.rin_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.rin_ready !== 1'b1 || bus.rout_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_opcode got err=%b rin_rdy=%b vld=%b want 1 1 0", bus.err, bus.rin_ready, bus.rout_valid);
        end
        bus.rin_valid = 1'b1;
        bus.rin_data  = {4'd0, 4'd15, 25'd0};
        @(posedge clk); #1;
        bus.rin_valid = 1'b0;
        collect(0, -1, 20);
        checks++;
        if (bus.busy !== 1'b0 || bus.rin_ready !== 1'b0 || bus.load_start_ready !== 1'b1) begin
            failures++;
            $display("FAIL final_idle got busy=%b rin_rdy=%b lsr=%b want 0 0 1", bus.busy, bus.rin_ready, bus.load_start_ready);
        end
        bus.rin_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rin_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rout_valid !== 1'b0) begin
            failures++;
            $display("FAIL rin_after_done got rin_rdy=%b busy=%b vld=%b want 0 0 0", bus.rin_ready, bus.busy, bus.rout_valid);
        end
        bus.rin_valid = 1'b0;
    endtask

    task automatic test_stall_and_errors();
        do_load(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.load_done_valid = 1'b0;
        collect(0, 3, 20);
        checks++;
        if (bus.err !== 1'b1 || bus.rout_valid !== 1'b0) begin
            failures++;
            $display("FAIL sticky_err got err=%b vld=%b want 1 0", bus.err, bus.rout_valid);
        end
    endtask

    task automatic test_reset_in_send();
        bus.rin_valid = 1'b1;
        bus.rin_data  = {4'd0, 4'd15, 25'd0};
        @(posedge clk); #1;
        bus.rin_valid = 1'b0;
        collect(0, -1, 4);
        checks++;
        if (bus.busy !== 1'b1 || bus.rout_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_send got busy=%b vld=%b want 1 1", bus.busy, bus.rout_valid);
        end
        test_reset();
    endtask

    task automatic test_fresh_load();
        do_load(100, 1'b0, 1'b0);
        bus.load_done_valid = 1'b1;
        @(posedge clk); #1;
        bus.load_done_valid = 1'b0;
        collect(100, -1, 20);
        checks++;
        if (bus.err !== 1'b0 || bus.rin_ready !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL fresh_end got err=%b rin_rdy=%b busy=%b want 0 1 1", bus.err, bus.rin_ready, bus.busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus.load_start_valid = 1'b0;
        bus.wr_valid         = 1'b0;
        bus.wr_addr          = '0;
        bus.wr_data          = '0;
        bus.load_done_valid  = 1'b0;
        bus.rin_valid        = 1'b0;
        bus.rin_data         = '0;
        bus.rout_ready       = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_first_pass();
        test_replay();
        test_stall_and_errors();
        test_reset_in_send();
        test_fresh_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
